// File: rtl/ptv_req_ctrl_if.sv
// rtl/ptv_req_ctrl_if.sv - request, config, decoder and response signal bundle for ptv_req_ctrl
interface ptv_req_ctrl_if #(
  parameter int BITMAP = 128,
  parameter int TAG_W  = 4
);
  localparam int ADDR_W = $clog2(BITMAP);
  localparam int STAGES = ADDR_W;
  localparam int NODES  = BITMAP / 2;
  localparam int STG_W  = $clog2(STAGES);

  logic                         i_req_vld;
  logic                         o_req_rdy;
  logic [ADDR_W-1:0]            i_req_paddr;
  logic [TAG_W-1:0]             i_req_tag;
  logic                         i_cfg_vld;
  logic                         o_cfg_rdy;
  logic [STG_W-1:0]             i_cfg_stg;
  logic [NODES-1:0]             i_cfg_data;
  logic                         i_cfg_commit;
  logic                         o_cfg_done;
  logic                         o_cfg_err;
  logic [ADDR_W-1:0]            o_dec_paddr;
  logic                         o_dec_oreg_en;
  logic [STAGES-1:0][NODES-1:0] o_dec_scb;
  logic [ADDR_W-1:0]            i_dec_vaddr;
  logic                         o_rsp_vld;
  logic                         i_rsp_rdy;
  logic [ADDR_W-1:0]            o_rsp_vaddr;
  logic [TAG_W-1:0]             o_rsp_tag;

  modport slave (
    input  i_req_vld, i_req_paddr, i_req_tag,
    input  i_cfg_vld, i_cfg_stg, i_cfg_data, i_cfg_commit,
    input  i_dec_vaddr, i_rsp_rdy,
    output o_req_rdy, o_cfg_rdy, o_cfg_done, o_cfg_err,
    output o_dec_paddr, o_dec_oreg_en, o_dec_scb,
    output o_rsp_vld, o_rsp_vaddr, o_rsp_tag
  );

  modport master (
    output i_req_vld, i_req_paddr, i_req_tag,
    output i_cfg_vld, i_cfg_stg, i_cfg_data, i_cfg_commit,
    output i_dec_vaddr, i_rsp_rdy,
    input  o_req_rdy, o_cfg_rdy, o_cfg_done, o_cfg_err,
    input  o_dec_paddr, o_dec_oreg_en, o_dec_scb,
    input  o_rsp_vld, o_rsp_vaddr, o_rsp_tag
  );
endinterface

// File: rtl/ptv_req_ctrl.sv
// rtl/ptv_req_ctrl.sv - request queue, lookup sequencer and double-buffered SCB bank
module ptv_req_ctrl #(
  parameter int BITMAP = 128,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4
) (
  input logic           i_clk,
  input logic           i_rst_n,
  ptv_req_ctrl_if.slave bus
);
  localparam int ADDR_W = $clog2(BITMAP);
  localparam int STAGES = ADDR_W;
  localparam int NODES  = BITMAP / 2;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_CAPTURE, S_HOLD, S_SWAP} state_t;

  state_t                       state_q;
  logic [ADDR_W-1:0]            fifo_paddr_q [DEPTH];
  logic [TAG_W-1:0]             fifo_tag_q   [DEPTH];
  logic [PTR_W-1:0]             wr_ptr_q;
  logic [PTR_W-1:0]             rd_ptr_q;
  logic [CNT_W-1:0]             count_q;
  logic [CNT_W-1:0]             count_d;
  logic [STAGES-1:0][NODES-1:0] shadow_q;
  logic [STAGES-1:0][NODES-1:0] active_q;
  logic                         pending_q;
  logic                         cfg_done_q;
  logic                         cfg_err_q;
  logic [ADDR_W-1:0]            dec_paddr_q;
  logic                         oreg_en_q;
  logic                         rsp_vld_q;
  logic [ADDR_W-1:0]            rsp_vaddr_q;
  logic [TAG_W-1:0]             rsp_tag_q;

  logic              req_rdy;
  logic              push;
  logic              pop;
  logic              have_work;
  logic              resume;
  logic              swap_go;
  logic              lookup_go;
  logic              cfg_acc;
  logic              stg_ok;
  logic [ADDR_W-1:0] head_paddr;

  assign req_rdy = (count_q != FULL_CNT);
  assign push    = bus.i_req_vld && req_rdy;
  assign pop     = (state_q == S_CAPTURE);

  // A request arriving into an empty queue is forwarded straight to the
  // decoder so the idle-to-response latency stays at three cycles.
  assign have_work  = (count_q != '0) || push;
  assign head_paddr = (count_q != '0) ? fifo_paddr_q[rd_ptr_q] : bus.i_req_paddr;

  // IDLE and an accepted HOLD share one decision point; a pending swap wins.
  assign resume    = (state_q == S_IDLE) || ((state_q == S_HOLD) && bus.i_rsp_rdy);
  assign swap_go   = resume && pending_q;
  assign lookup_go = resume && !pending_q && have_work;

  assign cfg_acc = bus.i_cfg_vld && !pending_q;
  assign stg_ok  = (int'(bus.i_cfg_stg) < STAGES);

  // Occupancy bookkeeping; simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Request FIFO storage and wrapping pointers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_paddr_q[wr_ptr_q] <= bus.i_req_paddr;
        fifo_tag_q[wr_ptr_q]   <= bus.i_req_tag;
        wr_ptr_q               <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // Shadow writes, commit tracking and the shadow-to-active copy on swap entry.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      shadow_q   <= '0;
      active_q   <= '0;
      pending_q  <= 1'b0;
      cfg_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      cfg_done_q <= swap_go;
      cfg_err_q  <= cfg_acc && !stg_ok;
      if (cfg_acc && stg_ok) begin
        shadow_q[bus.i_cfg_stg] <= bus.i_cfg_data;
      end
      if (swap_go) begin
        active_q  <= shadow_q;
        pending_q <= 1'b0;
      end else if (bus.i_cfg_commit) begin
        pending_q <= 1'b1;
      end
    end
  end

  // Lookup sequencer with registered decoder and response outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      dec_paddr_q <= '0;
      oreg_en_q   <= 1'b0;
      rsp_vld_q   <= 1'b0;
      rsp_vaddr_q <= '0;
      rsp_tag_q   <= '0;
    end else begin
      oreg_en_q <= 1'b0;
      case (state_q)
        S_IDLE, S_HOLD: begin
          if (resume) begin
            rsp_vld_q <= 1'b0;
            if (swap_go) begin
              state_q <= S_SWAP;
            end else if (lookup_go) begin
              state_q     <= S_LOOKUP;
              dec_paddr_q <= head_paddr;
              oreg_en_q   <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_LOOKUP: begin
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          rsp_vaddr_q <= bus.i_dec_vaddr;
          rsp_tag_q   <= fifo_tag_q[rd_ptr_q];
          rsp_vld_q   <= 1'b1;
          state_q     <= S_HOLD;
        end
        S_SWAP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_req_rdy     = req_rdy;
  assign bus.o_cfg_rdy     = !pending_q;
  assign bus.o_cfg_done    = cfg_done_q;
  assign bus.o_cfg_err     = cfg_err_q;
  assign bus.o_dec_paddr   = dec_paddr_q;
  assign bus.o_dec_oreg_en = oreg_en_q;
  assign bus.o_dec_scb     = active_q;
  assign bus.o_rsp_vld     = rsp_vld_q;
  assign bus.o_rsp_vaddr   = rsp_vaddr_q;
  assign bus.o_rsp_tag     = rsp_tag_q;
endmodule

// File: tb/tb_ptv_req_ctrl.sv
// tb/tb_ptv_req_ctrl.sv - self-checking bench for ptv_req_ctrl
module tb_ptv_req_ctrl;
  localparam int BITMAP = 128;
  localparam int DEPTH  = 4;
  localparam int TAG_W  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ptv_req_ctrl_if #(.BITMAP(BITMAP), .TAG_W(TAG_W)) bus ();

  ptv_req_ctrl #(.BITMAP(BITMAP), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  // Decoder stand-in: registered result = ~paddr ^ low bits of active stage 0.
  always @(posedge clk) begin
    if (!rst_n) bus.i_dec_vaddr <= '0;
    else if (bus.o_dec_oreg_en) bus.i_dec_vaddr <= ~bus.o_dec_paddr ^ bus.o_dec_scb[0][6:0];
  end

  int n_checks = 0;
  int n_pass = 0;

  logic [6:0][63:0] m_shadow = '0;
  logic [6:0][63:0] m_active = '0;
  bit               m_pending = 1'b0;
  bit               err_exp = 1'b0;
  logic [6:0]       q_paddr[$];
  logic [3:0]       q_tag[$];

  typedef struct {
    logic [6:0] paddr;
    logic [3:0] tag;
    logic [6:0] vaddr;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] exp_vaddr(input logic [6:0] p, input logic [63:0] b0);
    return ~p ^ b0[6:0];
  endfunction

  // Bounded wait: 0 = response valid, 1 = decoder enable, 2 = swap done.
  task automatic wait_for(input int which, input string name);
    int c = 0;
    logic hit;
    hit = 1'b0;
    while (c < 30) begin
      case (which)
        0: hit = bus.o_rsp_vld;
        1: hit = bus.o_dec_oreg_en;
        default: hit = bus.o_cfg_done;
      endcase
      if (hit) break;
      tick();
      c++;
    end
    chk(name, 512'(hit), 512'(1));
  endtask

  task automatic rnd_cycle(input bit drive);
    if (bus.o_cfg_done) begin
      chk("rnd_done_when_pending", 512'(m_pending), 512'(1));
      m_active  = m_shadow;
      m_pending = 1'b0;
    end
    chk("rnd_scb", 512'(bus.o_dec_scb), 512'(m_active));
    chk("rnd_cfg_rdy", 512'(bus.o_cfg_rdy), 512'(!m_pending));
    chk("rnd_cfg_err", 512'(bus.o_cfg_err), 512'(err_exp));
    err_exp = 1'b0;
    if (drive) begin
      bus.i_req_vld    = ($urandom_range(0, 1) == 1);
      bus.i_req_paddr  = 7'($urandom);
      bus.i_req_tag    = 4'($urandom);
      bus.i_rsp_rdy    = ($urandom_range(0, 1) == 1);
      bus.i_cfg_vld    = ($urandom_range(0, 9) == 0);
      bus.i_cfg_stg    = 3'($urandom_range(0, 7));
      bus.i_cfg_data   = {$urandom, $urandom};
      bus.i_cfg_commit = ($urandom_range(0, 29) == 0);
    end else begin
      bus.i_req_vld    = 1'b0;
      bus.i_rsp_rdy    = 1'b1;
      bus.i_cfg_vld    = 1'b0;
      bus.i_cfg_commit = 1'b0;
    end
    if (bus.o_rsp_vld && bus.i_rsp_rdy) begin
      chk("rnd_rsp_expected", 512'(q_tag.size() > 0), 512'(1));
      if (q_tag.size() > 0) begin
        chk("rnd_rsp_tag", 512'(bus.o_rsp_tag), 512'(q_tag[0]));
        chk("rnd_rsp_vaddr", 512'(bus.o_rsp_vaddr), 512'(exp_vaddr(q_paddr[0], m_active[0])));
        void'(q_tag.pop_front());
        void'(q_paddr.pop_front());
      end
    end
    if (bus.i_req_vld && bus.o_req_rdy) begin
      q_paddr.push_back(bus.i_req_paddr);
      q_tag.push_back(bus.i_req_tag);
    end
    if (bus.i_cfg_vld && bus.o_cfg_rdy) begin
      if (bus.i_cfg_stg < 3'd7) m_shadow[bus.i_cfg_stg] = bus.i_cfg_data;
      else err_exp = 1'b1;
    end
    if (bus.i_cfg_commit && !m_pending) m_pending = 1'b1;
    tick();
  endtask

  initial begin
    int n_acc;
    int got;
    int seen;
    logic [6:0][63:0] prior;

    vecs[0] = '{7'h15, 4'd3,  7'h6A};
    vecs[1] = '{7'h00, 4'd0,  7'h7F};
    vecs[2] = '{7'h7F, 4'd15, 7'h00};
    vecs[3] = '{7'h40, 4'd9,  7'h3F};
    vecs[4] = '{7'h2C, 4'd12, 7'h53};

    bus.i_req_vld = 1'b0; bus.i_req_paddr = '0; bus.i_req_tag = '0;
    bus.i_cfg_vld = 1'b0; bus.i_cfg_stg = '0; bus.i_cfg_data = '0;
    bus.i_cfg_commit = 1'b0; bus.i_rsp_rdy = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_req_rdy", 512'(bus.o_req_rdy), 512'(1));
    chk("rst_cfg_rdy", 512'(bus.o_cfg_rdy), 512'(1));
    chk("rst_rsp_vld", 512'(bus.o_rsp_vld), 512'(0));
    chk("rst_oreg_en", 512'(bus.o_dec_oreg_en), 512'(0));
    chk("rst_cfg_done", 512'(bus.o_cfg_done), 512'(0));
    chk("rst_cfg_err", 512'(bus.o_cfg_err), 512'(0));
    chk("rst_dec_paddr", 512'(bus.o_dec_paddr), 512'(0));
    chk("rst_rsp_vaddr", 512'(bus.o_rsp_vaddr), 512'(0));
    chk("rst_rsp_tag", 512'(bus.o_rsp_tag), 512'(0));
    chk("rst_scb", 512'(bus.o_dec_scb), 512'(0));
    rst_n = 1'b1;
    tick();

    // Single lookups with minimum latency, bank all zero
    for (int i = 0; i < 5; i++) begin
      chk("vec_req_rdy", 512'(bus.o_req_rdy), 512'(1));
      bus.i_req_vld = 1'b1; bus.i_req_paddr = vecs[i].paddr; bus.i_req_tag = vecs[i].tag;
      tick();
      bus.i_req_vld = 1'b0;
      chk("vec_oreg_en_t1", 512'(bus.o_dec_oreg_en), 512'(1));
      chk("vec_dec_paddr_t1", 512'(bus.o_dec_paddr), 512'(vecs[i].paddr));
      tick();
      chk("vec_oreg_en_t2", 512'(bus.o_dec_oreg_en), 512'(0));
      chk("vec_rsp_vld_t2", 512'(bus.o_rsp_vld), 512'(0));
      tick();
      chk("vec_rsp_vld_t3", 512'(bus.o_rsp_vld), 512'(1));
      chk("vec_rsp_vaddr", 512'(bus.o_rsp_vaddr), 512'(vecs[i].vaddr));
      chk("vec_rsp_tag", 512'(bus.o_rsp_tag), 512'(vecs[i].tag));
      tick();
      chk("vec_rsp_vld_after", 512'(bus.o_rsp_vld), 512'(0));
      chk("vec_dec_paddr_hold", 512'(bus.o_dec_paddr), 512'(vecs[i].paddr));
    end

    // Backpressure: capacity is the queue plus the held response
    bus.i_rsp_rdy = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      if (!bus.o_req_rdy) break;
      bus.i_req_vld = 1'b1; bus.i_req_paddr = 7'(32'h20 + i); bus.i_req_tag = 4'(i);
      n_acc++;
      tick();
    end
    bus.i_req_vld = 1'b0;
    chk("bp_accepted", 512'(n_acc), 512'(DEPTH + 1));
    repeat (3) tick();
    chk("bp_req_rdy_full", 512'(bus.o_req_rdy), 512'(0));
    chk("bp_rsp_held", 512'(bus.o_rsp_vld), 512'(1));
    chk("bp_rsp_held_tag", 512'(bus.o_rsp_tag), 512'(0));
    bus.i_rsp_rdy = 1'b1;
    got = 0;
    for (int c = 0; c < 60 && got < 5; c++) begin
      if (bus.o_rsp_vld) begin
        chk("bp_tag_order", 512'(bus.o_rsp_tag), 512'(got));
        chk("bp_vaddr", 512'(bus.o_rsp_vaddr), 512'(exp_vaddr(7'(32'h20 + got), 64'h0)));
        got++;
      end
      tick();
    end
    chk("bp_all_returned", 512'(got), 512'(5));
    chk("bp_req_rdy_back", 512'(bus.o_req_rdy), 512'(1));

    // Commit ordering around a held response
    for (int s = 0; s < 7; s++) begin
      bus.i_cfg_vld = 1'b1; bus.i_cfg_stg = 3'(s);
      bus.i_cfg_data = 64'hAA | (64'(s + 1) << 8);
      m_shadow[s] = bus.i_cfg_data;
      chk("cm_cfg_rdy", 512'(bus.o_cfg_rdy), 512'(1));
      tick();
    end
    bus.i_cfg_vld = 1'b0;
    bus.i_rsp_rdy = 1'b0;
    bus.i_req_vld = 1'b1; bus.i_req_paddr = 7'h11; bus.i_req_tag = 4'd5;
    tick();
    bus.i_req_paddr = 7'h33; bus.i_req_tag = 4'd6;
    tick();
    bus.i_req_vld = 1'b0;
    wait_for(0, "cm_first_rsp");
    chk("cm_first_tag", 512'(bus.o_rsp_tag), 512'(5));
    chk("cm_first_vaddr", 512'(bus.o_rsp_vaddr), 512'(exp_vaddr(7'h11, m_active[0])));
    bus.i_cfg_commit = 1'b1;
    tick();
    bus.i_cfg_commit = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("cm_no_done_in_hold", 512'(bus.o_cfg_done), 512'(0));
      chk("cm_cfg_rdy_pending", 512'(bus.o_cfg_rdy), 512'(0));
      chk("cm_old_bank", 512'(bus.o_dec_scb), 512'(m_active));
      tick();
    end
    chk("cm_rsp_stable", 512'(bus.o_rsp_tag), 512'(5));
    bus.i_rsp_rdy = 1'b1;
    tick();
    bus.i_rsp_rdy = 1'b0;
    m_active = m_shadow;
    chk("cm_done_pulse", 512'(bus.o_cfg_done), 512'(1));
    chk("cm_new_bank", 512'(bus.o_dec_scb), 512'(m_active));
    tick();
    chk("cm_done_once", 512'(bus.o_cfg_done), 512'(0));
    chk("cm_cfg_rdy_free", 512'(bus.o_cfg_rdy), 512'(1));
    wait_for(1, "cm_second_lookup");
    chk("cm_second_paddr", 512'(bus.o_dec_paddr), 512'(7'h33));
    chk("cm_second_bank", 512'(bus.o_dec_scb), 512'(m_active));
    wait_for(0, "cm_second_rsp");
    chk("cm_second_tag", 512'(bus.o_rsp_tag), 512'(6));
    chk("cm_second_vaddr", 512'(bus.o_rsp_vaddr), 512'(exp_vaddr(7'h33, m_active[0])));
    bus.i_rsp_rdy = 1'b1;
    tick();

    // Out-of-range stage write is dropped
    prior = m_shadow;
    bus.i_cfg_vld = 1'b1; bus.i_cfg_stg = 3'd7; bus.i_cfg_data = '1;
    chk("bad_cfg_rdy", 512'(bus.o_cfg_rdy), 512'(1));
    tick();
    bus.i_cfg_vld = 1'b0;
    chk("bad_err_pulse", 512'(bus.o_cfg_err), 512'(1));
    tick();
    chk("bad_err_once", 512'(bus.o_cfg_err), 512'(0));
    bus.i_cfg_commit = 1'b1;
    tick();
    bus.i_cfg_commit = 1'b0;
    wait_for(2, "bad_commit_done");
    chk("bad_bank_is_prior", 512'(bus.o_dec_scb), 512'(prior));
    tick();

    // Write and commit in the same cycle: the write joins the swap
    bus.i_cfg_vld = 1'b1; bus.i_cfg_stg = 3'd2; bus.i_cfg_data = 64'h0123_4567_89AB_CDEF;
    bus.i_cfg_commit = 1'b1;
    m_shadow[2] = bus.i_cfg_data;
    tick();
    bus.i_cfg_vld = 1'b0; bus.i_cfg_commit = 1'b0;
    wait_for(2, "same_cycle_done");
    m_active = m_shadow;
    chk("same_cycle_bank", 512'(bus.o_dec_scb), 512'(m_active));
    tick();

    // Reset during CAPTURE with two entries queued
    bus.i_rsp_rdy = 1'b1;
    bus.i_req_vld = 1'b1; bus.i_req_paddr = 7'h01; bus.i_req_tag = 4'd1;
    tick();
    bus.i_req_paddr = 7'h02; bus.i_req_tag = 4'd2;
    tick();
    bus.i_req_paddr = 7'h03; bus.i_req_tag = 4'd3;
    rst_n = 1'b0;
    tick();
    bus.i_req_vld = 1'b0;
    chk("mid_rst_req_rdy", 512'(bus.o_req_rdy), 512'(1));
    chk("mid_rst_cfg_rdy", 512'(bus.o_cfg_rdy), 512'(1));
    chk("mid_rst_rsp_vld", 512'(bus.o_rsp_vld), 512'(0));
    tick();
    rst_n = 1'b1;
    m_shadow = '0; m_active = '0; m_pending = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.o_rsp_vld || bus.o_dec_oreg_en) seen++;
      tick();
    end
    chk("mid_rst_no_activity", 512'(seen), 512'(0));
    chk("mid_rst_scb_zero", 512'(bus.o_dec_scb), 512'(0));
    chk("mid_rst_req_rdy_after", 512'(bus.o_req_rdy), 512'(1));

    // Randomised traffic against the queue/bank model
    for (int c = 0; c < 2000; c++) rnd_cycle(1'b1);
    for (int c = 0; c < 300; c++) begin
      if (q_tag.size() == 0 && !m_pending && !bus.o_rsp_vld) break;
      rnd_cycle(1'b0);
    end
    chk("rnd_drained", 512'(q_tag.size()), 512'(0));
    chk("rnd_no_pending", 512'(m_pending), 512'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
